// File: rtl/peripheral_nibble_adder_seq_if.sv
// Bundle between the nibble sequencer, its application-side requester and the external 4-bit
// ripple-carry adder slice.
interface peripheral_nibble_adder_seq_if #(
    parameter int unsigned WIDTH = 16
) ();
    // Application side
    logic             start;
    logic             sub;
    logic             cin_in;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    // Adder slice side
    logic [3:0]       add_x;
    logic [3:0]       add_y;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    // Sequencer view
    modport slave (
        input  start, sub, cin_in, op_a, op_b, add_sum, add_cout,
        output busy, done, result, cout, ovf, add_x, add_y, add_cin
    );

    // Requester / adder view
    modport master (
        output start, sub, cin_in, op_a, op_b, add_sum, add_cout,
        input  busy, done, result, cout, ovf, add_x, add_y, add_cin
    );
endinterface

// File: rtl/peripheral_nibble_adder_seq.sv
// Nibble-serial add/subtract sequencer. Feeds one 4-bit slice of each operand per cycle to an
// external ripple-carry adder, threads the carry between slices, and assembles the result.
module peripheral_nibble_adder_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                         mclk,
    input  logic                         puc_rst,
    peripheral_nibble_adder_seq_if.slave bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             busy, done, add_cin;
    logic [3:0]       add_x, add_y;

    // Next-state, datapath capture and decoded outputs
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;
        add_x    = 4'h0;
        add_y    = 4'h0;
        add_cin  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1; cin_in only matters for addition
                    a_d      = bus.op_a;
                    b_d      = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d  = bus.sub ? 1'b1 : bus.cin_in;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                add_x   = a_q[4*idx_q +: 4];
                add_y   = b_q[4*idx_q +: 4];
                add_cin = carry_q;
                result_d[4*idx_q +: 4] = bus.add_sum;
                carry_d = bus.add_cout;
                if (idx_q == IdxLast) begin
                    // Sign of the top slice decides overflow against the effective operands
                    cout_d  = bus.add_cout;
                    ovf_d   = (a_q[WIDTH-1] ^ bus.add_sum[3]) & (b_q[WIDTH-1] ^ bus.add_sum[3]);
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.result  = result_q;
    assign bus.cout    = cout_q;
    assign bus.ovf     = ovf_q;
    assign bus.add_x   = add_x;
    assign bus.add_y   = add_y;
    assign bus.add_cin = add_cin;
endmodule
